// File: rtl/pipeline_stage_reg.sv
// pipeline_stage_reg: elastic valid/ready pipeline register with a 2-entry
// skid buffer (main + skid), registered in_ready and bubble-inserting flush.
// Optional macro PIPE_STAGE_PERF_EN adds saturating stall/bubble counters.
module pipeline_stage_reg #(
  parameter int unsigned CTRL_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 160,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0]  stall_cycles,
  output logic [CNT_WIDTH-1:0]  bubble_cycles
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  out_valid_q, out_valid_d;
  logic                  in_ready_q, in_ready_d;
  logic [CTRL_WIDTH-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
  logic [CTRL_WIDTH-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic                  accept;
  logic                  drain;

  assign accept    = in_valid & in_ready_q;
  assign drain     = out_valid_q & out_ready;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_ctrl  = main_ctrl_q;
  assign out_data  = main_data_q;

  // Next-state for the main/skid entries; flush overrides normal operation.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d     = HALF;
          out_valid_d = 1'b1;
          main_ctrl_d = in_ctrl;
          main_data_d = in_data;
        end
      end
      HALF: begin
        if (accept && drain) begin
          main_ctrl_d = in_ctrl;
          main_data_d = in_data;
        end else if (accept) begin
          state_d     = FULL;
          skid_ctrl_d = in_ctrl;
          skid_data_d = in_data;
        end else if (drain) begin
          state_d     = EMPTY;
          out_valid_d = 1'b0;
          main_ctrl_d = '0;
        end
      end
      FULL: begin
        if (drain) begin
          state_d     = HALF;
          main_ctrl_d = skid_ctrl_q;
          main_data_d = skid_data_q;
        end
      end
      default: begin
        state_d     = EMPTY;
        out_valid_d = 1'b0;
        main_ctrl_d = '0;
      end
    endcase
    // A bubble keeps the stale data but zeroes control so it acts as a NOP.
    if (flush) begin
      state_d     = EMPTY;
      out_valid_d = 1'b0;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end
  end

  // in_ready is computed from the next state so it can be a plain flop.
  always_comb begin
    in_ready_d = (state_d != FULL);
  end

  // Occupancy is a direct decode of the registered state.
  always_comb begin
    occupancy = 2'd0;
    unique case (state_q)
      EMPTY:   occupancy = 2'd0;
      HALF:    occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  // State and payload registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_WIDTH-1:0] stall_q;
  logic [CNT_WIDTH-1:0] bubble_q;

  assign stall_cycles  = stall_q;
  assign bubble_cycles = bubble_q;

  // Saturating counters; only reset clears them, flush does not.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (out_valid_q && !out_ready && (stall_q != '1)) begin
        stall_q <= stall_q + 1'b1;
      end
      if (!out_valid_q && (bubble_q != '1)) begin
        bubble_q <= bubble_q + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Self-checking bench for pipeline_stage_reg: per-cycle vector table for
// handshake/occupancy, scoreboard for payload order and content.
module tb_pipeline_stage_reg;

`ifdef PIPE_STAGE_PERF_EN
  localparam int unsigned TB_CNT = 4;
`else
  localparam int unsigned TB_CNT = 32;
`endif

  logic         clk;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [15:0]  in_ctrl;
  logic [159:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [15:0]  out_ctrl;
  logic [159:0] out_data;
  logic [1:0]   occupancy;
`ifdef PIPE_STAGE_PERF_EN
  logic [TB_CNT-1:0] stall_cycles;
  logic [TB_CNT-1:0] bubble_cycles;
`endif

  pipeline_stage_reg #(
    .CTRL_WIDTH(16),
    .DATA_WIDTH(160),
    .CNT_WIDTH (TB_CNT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_ctrl      (in_ctrl),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_ctrl     (out_ctrl),
    .out_data     (out_data),
    .occupancy    (occupancy)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cycles (stall_cycles),
    .bubble_cycles(bubble_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        fl;
    logic        iv;
    logic [15:0] ic;
    logic        ordy;
    logic [1:0]  occ;
    logic        ir;
    logic        ov;
  } vec_t;

  typedef struct {
    logic [15:0]  ctrl;
    logic [159:0] data;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [159:0] mk(input logic [15:0] c);
    logic [15:0] x;
    x = c ^ 16'hC3C3;
    return {10{x}} ^ {c, 144'h0};
  endfunction

  function automatic void add(input logic rst, fl, iv, input logic [15:0] ic,
                              input logic ordy, input logic [1:0] occ,
                              input logic ir, ov);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.ic = ic; v.ordy = ordy;
    v.occ = occ; v.ir = ir; v.ov = ov;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive at negedge, scoreboard the handshake, then check
  // bubble/stability rules just after the rising edge.
  task automatic step(input logic rst, fl, iv, input logic [15:0] ic, input logic ordy);
    logic [15:0]  pc;
    logic [159:0] pd;
    logic         hold;
    exp_t         e;
    @(negedge clk);
    reset = rst; flush = fl; in_valid = iv; in_ctrl = ic; in_data = mk(ic);
    out_ready = ordy;
    #1;
    hold = out_valid & ~out_ready;
    pc   = out_ctrl;
    pd   = out_data;
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("drain_without_expected", 160'd1, 160'd0);
        end else begin
          e = sb.pop_front();
          chk("out_ctrl", {144'h0, out_ctrl}, {144'h0, e.ctrl});
          chk("out_data", out_data, e.data);
        end
      end
      if (fl) begin
        sb.delete();
      end else if (in_valid && in_ready) begin
        e.ctrl = ic;
        e.data = mk(ic);
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    if (!out_valid) chk("bubble_ctrl_zero", {144'h0, out_ctrl}, 160'h0);
    if (hold && !rst && !fl) begin
      chk("stall_ctrl_stable", {144'h0, out_ctrl}, {144'h0, pc});
      chk("stall_data_stable", out_data, pd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0;
    out_ready = 1'b0;

    //  rst fl iv ic        ordy occ   ir ov
    add(1, 0, 0, 16'h0000, 0, 2'd0, 1, 0);   // reset
    add(0, 0, 1, 16'h00A5, 1, 2'd1, 1, 1);   // 1-cycle latency from empty
    for (int unsigned k = 1; k <= 8; k++)
      add(0, 0, 1, 16'(k), 1, 2'd1, 1, 1);   // back-to-back stream
    add(0, 0, 0, 16'h0000, 1, 2'd0, 1, 0);
    add(0, 0, 1, 16'h0A0A, 0, 2'd1, 1, 1);   // A
    add(0, 0, 1, 16'h0B0B, 0, 2'd2, 0, 1);   // B into skid
    add(0, 0, 1, 16'h0C0C, 0, 2'd2, 0, 1);   // C held upstream
    add(0, 0, 1, 16'h0C0C, 0, 2'd2, 0, 1);
    add(0, 0, 1, 16'h0C0C, 1, 2'd1, 1, 1);   // A out, B to main
    add(0, 0, 1, 16'h0C0C, 1, 2'd1, 1, 1);   // B out, C in
    add(0, 0, 0, 16'h0000, 1, 2'd0, 1, 0);   // C out
    add(0, 0, 1, 16'h0D0D, 0, 2'd1, 1, 1);
    add(0, 0, 1, 16'h0E0E, 0, 2'd2, 0, 1);
    add(0, 1, 1, 16'h0F0F, 0, 2'd0, 1, 0);   // flush from FULL
    add(0, 0, 0, 16'h0000, 1, 2'd0, 1, 0);   // no stale entry
    add(0, 0, 1, 16'h1111, 1, 2'd1, 1, 1);
    add(0, 1, 1, 16'h2222, 1, 2'd0, 1, 0);   // flush: drain counts, accept dropped
    add(0, 0, 0, 16'h0000, 1, 2'd0, 1, 0);
    add(0, 0, 1, 16'h3333, 0, 2'd1, 1, 1);
    add(0, 0, 1, 16'h4444, 0, 2'd2, 0, 1);
    add(1, 0, 1, 16'h5555, 0, 2'd0, 1, 0);   // reset from FULL
    add(0, 0, 1, 16'h6666, 1, 2'd1, 1, 1);   // fresh payload in 1 cycle
    add(0, 0, 0, 16'h0000, 1, 2'd0, 1, 0);

    for (int unsigned i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].fl, tbl[i].iv, tbl[i].ic, tbl[i].ordy);
      chk($sformatf("occupancy[%0d]", i), {158'h0, occupancy}, {158'h0, tbl[i].occ});
      chk($sformatf("in_ready[%0d]", i),  {159'h0, in_ready},  {159'h0, tbl[i].ir});
      chk($sformatf("out_valid[%0d]", i), {159'h0, out_valid}, {159'h0, tbl[i].ov});
      if (tbl[i].rst) chk($sformatf("rst_data[%0d]", i), out_data, 160'h0);
    end

`ifdef PIPE_STAGE_PERF_EN
    begin
      logic [TB_CNT-1:0] b;
      step(0, 0, 1, 16'h0077, 0);
      repeat (20) step(0, 0, 0, 16'h0000, 0);
      chk("stall_saturated", {{(160-TB_CNT){1'b0}}, stall_cycles}, {{(160-TB_CNT){1'b0}}, {TB_CNT{1'b1}}});
      b = bubble_cycles;
      step(0, 1, 1, 16'h0088, 0);
      chk("stall_after_flush", {{(160-TB_CNT){1'b0}}, stall_cycles}, {{(160-TB_CNT){1'b0}}, {TB_CNT{1'b1}}});
      chk("bubble_after_flush", {{(160-TB_CNT){1'b0}}, bubble_cycles}, {{(160-TB_CNT){1'b0}}, b});
      step(1, 0, 0, 16'h0000, 0);
      chk("stall_after_reset", {{(160-TB_CNT){1'b0}}, stall_cycles}, 160'h0);
      chk("bubble_after_reset", {{(160-TB_CNT){1'b0}}, bubble_cycles}, 160'h0);
    end
`endif

    chk("scoreboard_empty", 160'(sb.size()), 160'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_stage_reg.md
Name: pipeline_stage_reg

Overview:
Parametrised, elastic pipeline stage register for the RV32 core. It generalises the fixed-field inter-stage registers into one reusable block with the following features:
- generic control and data payload widths;
- valid/ready handshake;
- a 2-entry skid buffer that gives full throughput with a registered in_ready;
- flush that inserts a bubble.

It is instantiated between IF/ID, ID/EX, EX/MEM and MEM/WB. The hazard unit drives flush and out_ready (stall).

Parameters:
CTRL_WIDTH, 16, width of control payload (write enables, selects); forced to zero in bubbles.
DATA_WIDTH, 160, width of data payload (pc, operands, imm, etc.); not cleared by flush.
CNT_WIDTH, 32, width of performance counters (only used with PIPE_STAGE_PERF_EN).

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
flush  input  1  synchronous discard of all held entries and the current input
in_valid  input  1  upstream has a payload
in_ready  output  1  stage can accept; registered, equals (state != FULL)
in_ctrl  input  CTRL_WIDTH  upstream control payload
in_data  input  DATA_WIDTH  upstream data payload
out_valid  output  1  main entry holds a valid payload
out_ready  input  1  downstream accepts; 0 = stall
out_ctrl  output  CTRL_WIDTH  main entry control; all-zero whenever out_valid=0
out_data  output  DATA_WIDTH  main entry data
occupancy  output  2  number of held entries, 0..2
stall_cycles  output  CNT_WIDTH  (PIPE_STAGE_PERF_EN only) cycles with out_valid & !out_ready
bubble_cycles  output  CNT_WIDTH  (PIPE_STAGE_PERF_EN only) cycles with out_valid=0

Behaviour:
- Storage: main entry (drives outputs) and skid entry. States are EMPTY (0), HALF (main), FULL (main + skid).
- accept = in_valid & in_ready; drain = out_valid & out_ready.
- Priority: reset > flush > normal operation.
- Reset (sync): state EMPTY, out_valid=0, out_ctrl=0, out_data=0, skid cleared, occupancy=0, counters=0. in_ready=1 from the first cycle after reset deasserts.
- Flush:
  - next state EMPTY; out_valid=0, out_ctrl=0; out_data holds; skid discarded.
  - A same-cycle accept is dropped and a same-cycle drain still counts as consumed downstream.
  - in_ready=1 next cycle.
- EMPTY:
  - accept -> HALF, main<=in.
  - otherwise stay.
- HALF:
  - accept & drain -> HALF, main<=in.
  - accept & !drain -> FULL, skid<=in.
  - !accept & drain -> EMPTY, out_ctrl<=0.
  - otherwise hold.
- FULL (in_ready=0):
  - drain -> HALF, main<=skid.
  - otherwise hold.
  - in_valid is ignored.
- Latency: 1 cycle from in to out when EMPTY. Throughput is 1 transfer/cycle in steady state.
- Skid path adds no latency beyond the queued order. Ordering is strictly FIFO.
- Stability: while out_valid & !out_ready, out_ctrl/out_data must not change (except on flush/reset).
- out_valid=0 implies out_ctrl=0. This makes a bubble equivalent to a NOP (no reg/mem/csr write).
- in_ready is a flop output with no combinational path from out_ready.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- When defined:
  - stall_cycles increments each cycle with out_valid & !out_ready.
  - bubble_cycles increments each cycle with out_valid=0.
  - Both saturate at all-ones and are cleared only by reset (not flush).
- When undefined:
  - the ports and counters are absent.
  - all other behaviour is identical.

Test Plan:
- Reset, then in_valid=1, in_ctrl=16'h00A5, in_data=X, out_ready=1 -> next cycle out_valid=1, out_ctrl=16'h00A5, out_data=X, occupancy=1, in_ready=1.
- Stream 8 back-to-back payloads (ctrl = 1..8) with out_ready=1 -> out_ctrl shows 1..8 on 8 consecutive cycles, no gaps, in_ready never deasserts.
- Present A, B, C on consecutive cycles with out_ready=0 -> after B occupancy=2, in_ready=0, C is held upstream. Raise out_ready -> A, B, C emerge in order and out_data stays constant during the stall.
- FULL state, assert flush for 1 cycle with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1, and no stale entry appears afterwards.
- Assert reset mid-stream with FULL state -> next cycle all outputs at reset values, in_ready=1, and a fresh payload passes in 1 cycle.
- PIPE_STAGE_PERF_EN, CNT_WIDTH=4: hold out_valid=1/out_ready=0 for 20 cycles -> stall_cycles saturates at 4'hF. Flush -> counters unchanged. Reset -> counters 0.
